shared_resource_arbiter: RTL
============================

Name: shared_resource_arbiter

Overview:
- Arbitrates one multi-cycle shared execution resource between pipeline 1 and pipeline 2, round-robin.
- Holds the losing requester, and the winner until its result returns, with per-pipeline stall outputs.
- Owner flushes are handled by draining and discarding the in-flight result.
- Sits inside the pipeline wrapper, between the two pipelines' resource-using stage and the shared unit.

Parameters:
- DATA_W, 32, operand/result width.
- TIMEOUT_CYCLES, 64, watchdog limit in BUSY/DRAIN cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- req_1  input  1  pipeline 1 stage holds an op needing the resource
- req_2  input  1  pipeline 2 stage holds an op needing the resource
- op_data_1  input  DATA_W  pipeline 1 operand
- op_data_2  input  DATA_W  pipeline 2 operand
- flush_1  input  1  pipeline 1 flush
- flush_2  input  1  pipeline 2 flush
- stall_1  output  1  hold pipeline 1
- stall_2  output  1  hold pipeline 2
- res_start  output  1  one-cycle launch pulse to the resource
- res_operand  output  DATA_W  operand to the resource
- res_done  input  1  resource result valid, one cycle
- res_result  input  DATA_W  resource result
- rsp_valid_1  output  1  result for pipeline 1, one cycle
- rsp_valid_2  output  1  result for pipeline 2, one cycle
- rsp_data  output  DATA_W  result data, qualified by rsp_valid_x
- timeout_err  output  1  sticky watchdog error; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async) values:
  - state=IDLE, owner=1, priority pointer favours pipeline 1.
  - res_start=0, res_operand=0, rsp_valid_1/2=0, rsp_data=0, timeout_err=0.
  - Reset mid-operation abandons any in-flight op; a later res_done is ignored (state IDLE).
- Eligibility: elig_x = req_x & ~flush_x & ~rsp_valid_x. A req is not re-granted in the cycle its response is delivered.
- Stall is combinational: stall_x = req_x & ~flush_x & ~rsp_valid_x.
  - The requester stays stalled from the first req cycle until its rsp_valid_x cycle.
- States: IDLE, BUSY, DRAIN. All outputs other than stall_x are registered.
- IDLE:
  - If any elig_x, grant one winner: the only eligible requester, or the pointer's favourite if both are eligible.
  - On grant: owner<=winner, res_operand<=op_data_winner, res_start<=1, state<=BUSY.
  - res_done in IDLE is ignored.
- BUSY:
  - res_start is high only in the first BUSY cycle.
  - res_done & ~flush_owner: rsp_data<=res_result, rsp_valid_owner<=1 (one cycle), pointer<=other pipeline, state<=IDLE.
  - flush_owner & ~res_done: state<=DRAIN.
  - flush_owner & res_done in the same cycle: result discarded, no rsp_valid, pointer<=other, state<=IDLE.
  - flush of the non-owner has no effect on the FSM.
- DRAIN:
  - Wait for res_done, discard it, pointer<=other, state<=IDLE.
  - New requests are not granted while in DRAIN.
- Latency (request in IDLE cycle T, resource latency L, res_done at T+1+L): res_start at T+1, rsp_valid at T+2+L. Min grant-to-response turnaround is 3 cycles.
- A pipeline's back-to-back requests interleave with the other pipeline when both are waiting. One op per pipeline per grant.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to BUSY/DRAIN and increments each BUSY/DRAIN cycle.
  - Reaching TIMEOUT_CYCLES without res_done: timeout_err<=1 (sticky until reset), no rsp_valid, pointer<=other, state<=IDLE.
- When undefined: no counter; timeout_err constant 0; BUSY/DRAIN wait indefinitely.

Test Plan:
- Single request: req_1=1, op_data_1=0x0000_0005 at cycle 2, resource returns 0x0000_0019 with L=2.
  - Required: res_start=1/res_operand=5 at cycle 3; rsp_valid_1=1, rsp_data=0x19 at cycle 6.
  - Required: stall_1 high cycles 2-5, low at 6.
- Contention: req_1 and req_2 both high from reset release.
  - Required: pipeline 1 served first, then pipeline 2.
  - Required: with both held continuously, grants alternate 1,2,1,2 and stall_2 stays high until its rsp_valid_2.
- Owner flush: pipeline 2 owns, flush_2 pulsed 1 cycle after res_start, res_done 3 cycles later.
  - Required: no rsp_valid_2; a pending req_1 is granted only in the cycle after the discarded res_done.
- Simultaneous flush_owner and res_done: no rsp_valid; next grant goes to the other pipeline; state IDLE next cycle.
- Reset mid-BUSY: assert reset while awaiting res_done, then deliver res_done after release.
  - Required: all outputs 0 immediately, and the late res_done produces no rsp_valid.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, res_done never returns.
  - Required: timeout_err=1 eight BUSY cycles after res_start and remains 1; the next request is granted normally.

Source files
------------

// File: rtl/shared_resource_arbiter_if.sv
// Handshake bundle between the two pipelines, the shared
// resource and the arbiter that sits between them.
interface shared_resource_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req_1;
    logic              req_2;
    logic [DATA_W-1:0] op_data_1;
    logic [DATA_W-1:0] op_data_2;
    logic              flush_1;
    logic              flush_2;
    logic              stall_1;
    logic              stall_2;
    logic              res_start;
    logic [DATA_W-1:0] res_operand;
    logic              res_done;
    logic [DATA_W-1:0] res_result;
    logic              rsp_valid_1;
    logic              rsp_valid_2;
    logic [DATA_W-1:0] rsp_data;
    logic              timeout_err;

    modport master (
        output req_1, req_2,
        output op_data_1, op_data_2,
        output flush_1, flush_2,
        input  stall_1, stall_2,
        input  res_start, res_operand,
        output res_done, res_result,
        input  rsp_valid_1, rsp_valid_2,
        input  rsp_data, timeout_err
    );

    modport slave (
        input  req_1, req_2,
        input  op_data_1, op_data_2,
        input  flush_1, flush_2,
        output stall_1, stall_2,
        output res_start, res_operand,
        input  res_done, res_result,
        output rsp_valid_1, rsp_valid_2,
        output rsp_data, timeout_err
    );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter for one multi-cycle resource shared by two pipelines.
// Optional watchdog enabled with `define ARB_TIMEOUT_EN.
module shared_resource_arbiter #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                      clk,
    input logic                      reset,
    shared_resource_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_t;

    state_t            state;
    logic              owner_2;
    logic              ptr_2;
    logic              elig_1;
    logic              elig_2;
    logic              win_2;
    logic              flush_own;
    logic              expired;
    logic [DATA_W-1:0] win_data;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign elig_1 = bus.req_1 & ~bus.flush_1 & ~bus.rsp_valid_1;
    assign elig_2 = bus.req_2 & ~bus.flush_2 & ~bus.rsp_valid_2;
    assign bus.stall_1 = elig_1;
    assign bus.stall_2 = elig_2;

    assign win_2     = elig_2 & (~elig_1 | ptr_2);
    assign win_data  = win_2 ? bus.op_data_2 : bus.op_data_1;
    assign flush_own = owner_2 ? bus.flush_2 : bus.flush_1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             to_drain;

    assign expired  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign to_drain = (state == BUSY) & flush_own &
                      ~bus.res_done & ~expired;

    // Counter is held at zero in IDLE so the first BUSY cycle counts as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt             <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            if (state == IDLE || to_drain)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state != IDLE && expired && !bus.res_done)
                bus.timeout_err <= 1'b1;
        end
    end
`else
    assign expired         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner_2         <= 1'b0;
            ptr_2           <= 1'b0;
            bus.res_start   <= 1'b0;
            bus.res_operand <= '0;
            bus.rsp_valid_1 <= 1'b0;
            bus.rsp_valid_2 <= 1'b0;
            bus.rsp_data    <= '0;
        end else begin
            bus.res_start   <= 1'b0;
            bus.rsp_valid_1 <= 1'b0;
            bus.rsp_valid_2 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (elig_1 || elig_2) begin
                        owner_2         <= win_2;
                        bus.res_operand <= win_data;
                        bus.res_start   <= 1'b1;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.res_done) begin
                        if (!flush_own) begin
                            bus.rsp_data    <= bus.res_result;
                            bus.rsp_valid_1 <= ~owner_2;
                            bus.rsp_valid_2 <= owner_2;
                        end
                        ptr_2 <= ~owner_2;
                        state <= IDLE;
                    end else if (expired) begin
                        ptr_2 <= ~owner_2;
                        state <= IDLE;
                    end else if (flush_own) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.res_done || expired) begin
                        ptr_2 <= ~owner_2;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
